// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single-issue ALU.
// One transaction at a time: grant in IDLE, compute in EXEC, hold the result in DONE.
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_id,
  output logic              busy,
  output logic [7:0]        done_cnt,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Requesters may drop or change payload freely once the transfer edge has passed;
  // the result stays stable while res_valid is high until res_ready is seen at an edge.

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic              prio_ptr;
  logic              grant_id;
  logic              hs;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        op_q;
  logic              id_q;
  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] alu_data;
  logic              alu_carry;

  // A lone requester always wins; a tie goes to the pointer.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = prio_ptr;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Readys are forced low while reset is held, even though state is already IDLE.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant_id;
  assign hs         = req0_ready || req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_ptr <= 1'b0;
      id_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
    end else if (hs) begin
      prio_ptr <= ~grant_id;
      id_q     <= grant_id;
      a_q      <= grant_id ? req1_a  : req0_a;
      b_q      <= grant_id ? req1_b  : req0_b;
      op_q     <= grant_id ? req1_op : req0_op;
    end
  end

  // Widened add/sub: bit DATA_W is carry-out for add and unsigned borrow for sub.
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    alu_data  = '0;
    alu_carry = 1'b0;
    case (op_q)
      3'd0: begin
        alu_data  = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      3'd1: begin
        alu_data  = diff[DATA_W-1:0];
        alu_carry = diff[DATA_W];
      end
      3'd2:    alu_data = a_q & b_q;
      3'd3:    alu_data = ~(a_q | b_q);
      3'd4:    alu_data = a_q | b_q;
      3'd5:    alu_data = ~(a_q & b_q);
      3'd6:    alu_data = a_q ^ b_q;
      3'd7:    alu_data = ~a_q;
      default: alu_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_carry <= 1'b0;
      res_id    <= 1'b0;
    end else if (state == EXEC) begin
      res_data  <= alu_data;
      res_carry <= alu_carry;
      res_id    <= id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= 8'd0;
    end else if ((state == DONE) && res_ready) begin
      done_cnt <= done_cnt + 8'd1;
    end
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed table of opcodes, hand-written corner sequences,
// then random traffic scored against a behavioural arbitration/ALU model.
module tb_alu_arbiter;

  localparam int DATA_W = 8;
  localparam int W      = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]        req0_op = '0, req1_op = '0;
  logic              res_valid, res_carry, res_id, busy;
  logic              res_ready = 1'b0;
  logic [DATA_W-1:0] res_data;
  logic [7:0]        done_cnt;
  logic [1:0]        dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_id(res_id),
    .busy(busy), .done_cnt(done_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [W-1:0]   exp_q[$];
  logic           model_ptr = 1'b0;
  int             exp_cnt   = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       c;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the opcode table with plain integer arithmetic.
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int d, output int c);
    int full;
    c = 0;
    case (op)
      0: begin full = a + b; d = full % 256; c = (full > 255) ? 1 : 0; end
      1: begin d = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: d = a & b;
      3: d = 255 - (a | b);
      4: d = a | b;
      5: d = 255 - (a & b);
      6: d = a ^ b;
      default: d = 255 - a;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_carry", res_carry, 0);
    check("rst_res_id", res_id, 0);
    check("rst_busy", busy, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    model_ptr = 1'b0;
    exp_cnt = 0;
    exp_q.delete();
  endtask

  task automatic run_txn(input logic v0, input logic v1,
                         input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1,
                         input int hold, input logic use_given,
                         input logic gid, input logic [7:0] gd, input logic gc);
    logic         exp_id;
    int           d, c;
    logic [7:0]   dd;
    logic         cc;
    logic [W-1:0] e;
    exp_id = (v0 && v1) ? model_ptr : v1;
    if (exp_id) ref_alu(int'(op1), int'(a1), int'(b1), d, c);
    else        ref_alu(int'(op0), int'(a0), int'(b0), d, c);
    dd = d[7:0];
    cc = c[0];
    if (use_given) begin
      exp_id = gid;
      dd = gd;
      cc = gc;
    end
    exp_q.push_back({exp_id, cc, dd});
    model_ptr = ~exp_id;

    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    #1;
    check("grant_req0_ready", req0_ready, !exp_id);
    check("grant_req1_ready", req1_ready, exp_id);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
    // Scramble payload and present res_ready during EXEC: both must be ignored.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'($urandom_range(0, 255)); req1_a = 8'($urandom_range(0, 255));
    req0_op = 3'($urandom_range(0, 7));  req1_op = 3'($urandom_range(0, 7));
    res_ready = 1'b1;
    check("exec_res_valid", res_valid, 0);
    check("exec_busy", busy, 1);
    @(posedge clk); #1;
    res_ready = (hold == 0);
    check("done_res_valid", res_valid, 1);
    e = exp_q.pop_front();
    check("res_data", res_data, e[7:0]);
    check("res_carry", res_carry, e[8]);
    check("res_id", res_id, e[9]);
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      #1;
      check("hold_req0_ready", req0_ready, 0);
      check("hold_req1_ready", req1_ready, 0);
      @(posedge clk); #1;
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, e[7:0]);
      check("hold_res_carry", res_carry, e[8]);
      check("hold_busy", busy, 1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_cnt++;
    check("post_res_valid", res_valid, 0);
    check("post_busy", busy, 0);
    check("done_cnt", done_cnt, exp_cnt % 256);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{3'd0, 8'h0F, 8'h3C, 8'h4B, 1'b0};
    tbl[1] = '{3'd1, 8'h0F, 8'h3C, 8'hD3, 1'b1};
    tbl[2] = '{3'd2, 8'h0F, 8'h3C, 8'h0C, 1'b0};
    tbl[3] = '{3'd3, 8'h0F, 8'h3C, 8'hC0, 1'b0};
    tbl[4] = '{3'd4, 8'h0F, 8'h3C, 8'h3F, 1'b0};
    tbl[5] = '{3'd5, 8'h0F, 8'h3C, 8'hF3, 1'b0};
    tbl[6] = '{3'd6, 8'h0F, 8'h3C, 8'h33, 1'b0};
    tbl[7] = '{3'd7, 8'h0F, 8'h3C, 8'hF0, 1'b0};

    do_reset();

    // Single requester 0: 20 + 10.
    run_txn(1, 0, 8'd20, 8'd10, 3'd0, 8'd0, 8'd0, 3'd0, 0, 1, 1'b0, 8'd30, 1'b0);

    // Reset pulse while idle clears the counter and the pointer.
    do_reset();

    // Simultaneous requests: req0 first, then req1 still pending.
    run_txn(1, 1, 8'd200, 8'd100, 3'd0, 8'd10, 8'd20, 3'd1, 0, 1, 1'b0, 8'd44, 1'b1);
    run_txn(0, 1, 8'd0, 8'd0, 3'd0, 8'd10, 8'd20, 3'd1, 0, 1, 1'b1, 8'd246, 1'b1);

    // Consumer stalls five cycles in DONE.
    run_txn(1, 0, 8'd7, 8'd9, 3'd6, 8'd0, 8'd0, 3'd0, 5, 0, 1'b0, 8'd0, 1'b0);

    // Opcode table, alternating requesters.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        run_txn(1, 0, tbl[i].a, tbl[i].b, tbl[i].op, 8'd0, 8'd0, 3'd0,
                0, 1, 1'b0, tbl[i].d, tbl[i].c);
      else
        run_txn(0, 1, 8'd0, 8'd0, 3'd0, tbl[i].a, tbl[i].b, tbl[i].op,
                1, 1, 1'b1, tbl[i].d, tbl[i].c);
    end

    // Reset during EXEC: transaction vanishes, pointer returns to req0.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_op = 3'd0;
    req1_valid = 1'b0;
    #1;
    check("abort_req0_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("abort_busy_exec", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_res_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done_cnt", done_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", res_valid, 0);
    end
    run_txn(1, 1, 8'd5, 8'd6, 3'd4, 8'd9, 8'd9, 3'd2, 0, 1, 1'b0, 8'd7, 1'b0);

    // Random traffic until 256 results have been consumed since the last reset.
    while (exp_cnt < 256) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(v0, v1,
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 2), 0, 1'b0, 8'd0, 1'b0);
    end
    check("done_cnt_wrap", done_cnt, 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
